// File: rtl/div_sequencer.sv
// Radix-2 restoring divider: one quotient bit per cycle, result strobe WIDTH+3 cycles after start (2 on divide-by-zero).
// Holds F/D/E via StallDiv from accept until the result cycle; a start presented in DONE is accepted back-to-back.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             StartE,
  input  logic             SignedE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             StallDiv,
  output logic             HasDivE,
  output logic [WIDTH-1:0] DivHiE,
  output logic [WIDTH-1:0] DivLoE,
  output logic             DivByZeroE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             has_div_q, has_div_d;
  logic [WIDTH-1:0] div_hi_q, div_hi_d;
  logic [WIDTH-1:0] div_lo_q, div_lo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic             neg_a;
  logic             neg_b;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    has_div_d = 1'b0;
    div_hi_d  = div_hi_q;
    div_lo_d  = div_lo_q;
    dbz_d     = dbz_q;

    // Partial remainder is compared at WIDTH+1 bits; when it is not smaller the
    // true difference is below the divisor, so a WIDTH-bit subtract is exact.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    diff   = rem_sh[WIDTH-1:0] - dvs_q;
    neg_a  = sgn_q & a_q[WIDTH-1];
    neg_b  = sgn_q & b_q[WIDTH-1];

    case (state_q)
      IDLE: begin
        if (StartE) begin
          a_d     = SrcAE;
          b_d     = SrcBE;
          sgn_d   = SignedE;
          state_d = SETUP;
        end
      end
      SETUP: begin
        quo_d  = neg_a ? -a_q : a_q;
        dvs_d  = neg_b ? -b_q : b_q;
        rem_d  = '0;
        qneg_d = neg_a ^ neg_b;
        rneg_d = neg_a;
        cnt_d  = CW'(WIDTH);
        if (b_q == '0) begin
          div_lo_d  = '1;
          div_hi_d  = a_q;
          dbz_d     = 1'b1;
          has_div_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d   = ITER;
        end
      end
      ITER: begin
        rem_d = ge ? diff : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        div_lo_d  = qneg_q ? -quo_q : quo_q;
        div_hi_d  = rneg_q ? -rem_q : rem_q;
        dbz_d     = 1'b0;
        has_div_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (StartE) begin
          a_d     = SrcAE;
          b_d     = SrcBE;
          sgn_d   = SignedE;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      has_div_q <= 1'b0;
      div_hi_q  <= '0;
      div_lo_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      has_div_q <= has_div_d;
      div_hi_q  <= div_hi_d;
      div_lo_q  <= div_lo_d;
      dbz_q     <= dbz_d;
    end
  end

  // Low in a plain DONE cycle so the divide instruction advances with its result.
  assign StallDiv   = ((state_q == IDLE || state_q == DONE) && StartE) ||
                      (state_q == SETUP) || (state_q == ITER) || (state_q == FIXUP);
  assign HasDivE    = has_div_q;
  assign DivHiE     = div_hi_q;
  assign DivLoE     = div_lo_q;
  assign DivByZeroE = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboarded bench for div_sequencer: random and directed divides against an arithmetic reference model.
module tb_div_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        StartE = 1'b0;
  logic        SignedE = 1'b0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        StallDiv;
  logic        HasDivE;
  logic [31:0] DivHiE;
  logic [31:0] DivLoE;
  logic        DivByZeroE;

  div_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .StartE(StartE), .SignedE(SignedE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .StallDiv(StallDiv), .HasDivE(HasDivE),
    .DivHiE(DivHiE), .DivLoE(DivLoE), .DivByZeroE(DivByZeroE)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_strobe = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit s, input int due);
    exp_t   e;
    longint sa, sd, q, r;
    e.due = due;
    e.dbz = 1'b0;
    if (b == 32'd0) begin
      e.lo  = 32'hFFFF_FFFF;
      e.hi  = a;
      e.dbz = 1'b1;
    end else if (s) begin
      sa   = longint'($signed(a));
      sd   = longint'($signed(b));
      q    = sa / sd;
      r    = sa % sd;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (HasDivE === 1'b1) begin
      exp_t e;
      n_strobe++;
      if (sb.size() == 0) begin
        chk("unexpected_hasdiv", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("div_lo", DivLoE, e.lo);
        chk("div_hi", DivHiE, e.hi);
        chk("div_by_zero", {31'd0, DivByZeroE}, {31'd0, e.dbz});
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit push);
    SrcAE   = a;
    SrcBE   = b;
    SignedE = s;
    StartE  = 1'b1;
    if (push) sb.push_back(model(a, b, s, cyc + ((b == 32'd0) ? 2 : 35)));
  endtask

  task automatic scramble();
    StartE  = 1'b0;
    SrcAE   = $urandom;
    SrcBE   = $urandom;
    SignedE = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    @(negedge clock);
    issue(a, b, s, 1'b1);
    #1 chk("stall_on_start", {31'd0, StallDiv}, 32'd1);
    @(negedge clock);
    scramble();
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    int          s0;
    logic [31:0] a, b;

    repeat (3) @(negedge clock);
    chk("rst_hasdiv", {31'd0, HasDivE}, 32'd0);
    chk("rst_lo", DivLoE, 32'd0);
    chk("rst_hi", DivHiE, 32'd0);
    chk("rst_dbz", {31'd0, DivByZeroE}, 32'd0);
    chk("rst_stall", {31'd0, StallDiv}, 32'd0);
    reset = 1'b0;

    // DIVU 100/7 with full stall/strobe profile.
    @(negedge clock);
    c = cyc;
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    #1 chk("stall_start_100_7", {31'd0, StallDiv}, 32'd1);
    for (int i = 1; i <= 35; i++) begin
      @(negedge clock);
      if (i == 1) scramble();
      #1;
      chk("stall_profile", {31'd0, StallDiv}, (i <= 34) ? 32'd1 : 32'd0);
      chk("hasdiv_profile", {31'd0, HasDivE}, (i == 35) ? 32'd1 : 32'd0);
    end
    drain();

    do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    do_div(32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
    do_div(32'd5, 32'd0, 1'b0);
    do_div(32'd9, 32'd3, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div(32'h8000_0000, 32'd0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      do_div(a, b, 1'($urandom_range(0, 1)));
    end

    // StartE held with fresh operands while the first divide is in flight.
    @(negedge clock);
    issue(32'd1000, 32'd33, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      SrcAE = $urandom;
      SrcBE = $urandom;
      SignedE = 1'($urandom_range(0, 1));
    end
    scramble();
    drain();

    // Back-to-back: new request presented in the DONE cycle.
    @(negedge clock);
    c = cyc;
    issue(32'hFFFF_FF9C, 32'd9, 1'b1, 1'b1);
    @(negedge clock);
    scramble();
    while (cyc < c + 35) @(negedge clock);
    #1;
    issue(32'd77, 32'hFFFF_FFF5, 1'b1, 1'b1);
    #1 chk("stall_done_start", {31'd0, StallDiv}, 32'd1);
    @(negedge clock);
    scramble();
    drain();

    // Reset in the 10th ITER cycle aborts with no result.
    @(negedge clock);
    c = cyc;
    issue(32'd123456, 32'd7, 1'b0, 1'b0);
    @(negedge clock);
    scramble();
    while (cyc < c + 11) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_stall", {31'd0, StallDiv}, 32'd0);
    chk("abort_hasdiv", {31'd0, HasDivE}, 32'd0);
    chk("abort_lo", DivLoE, 32'd0);
    chk("abort_hi", DivHiE, 32'd0);
    chk("abort_dbz", {31'd0, DivByZeroE}, 32'd0);
    s0 = n_strobe;
    repeat (40) @(negedge clock);
    #1 chk("abort_no_strobe", n_strobe - s0, 32'd0);

    do_div(32'd42, 32'd5, 1'b0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle radix-2 restoring divide controller sitting in the execute stage beside the ALU. Accepts a DIV/DIVU request, holds the pipeline through a stall line, and iterates one quotient bit per cycle. On completion it presents a one-cycle HasDiv/DivHi/DivLo result into the memory-stage pipeline register, for later writeback to HI/LO.

Parameters:
WIDTH, 32, operand/result width; quotient and remainder are WIDTH bits, iteration count = WIDTH

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
StartE  input  1  divide request from decode/execute control
SignedE  input  1  1 = DIV (two's complement), 0 = DIVU
SrcAE  input  WIDTH  dividend
SrcBE  input  WIDTH  divisor
StallDiv  output  1  to hazard unit; freezes F/D/E stages while high
HasDivE  output  1  one-cycle result-valid strobe to pipeline register
DivHiE  output  WIDTH  remainder
DivLoE  output  WIDTH  quotient
DivByZeroE  output  1  qualifies HasDivE; divisor was zero

Behaviour:
- States: IDLE, SETUP, ITER, FIXUP, DONE. Reset → IDLE; HasDivE=0, DivHiE=0, DivLoE=0, DivByZeroE=0, internal counter/registers=0.
- IDLE: StartE=1 at edge k latches SrcAE, SrcBE, SignedE → SETUP in cycle k+1. Operands not re-sampled afterwards.
- SETUP: signed mode takes magnitudes of both operands; records qneg = signA XOR signB, rneg = signA. Unsigned: magnitudes = raw, qneg=rneg=0. Counter loaded with WIDTH. Divisor==0 → DONE directly; otherwise → ITER.
- ITER: per cycle, shift {rem,quo} left 1; if rem ≥ divisor magnitude, subtract and set quo LSB=1. Counter decrements; after exactly WIDTH ITER cycles → FIXUP. Remainder comparison carried at WIDTH+1 bits, no overflow.
- FIXUP: negate quotient if qneg, remainder if rneg (two's complement, WIDTH-bit wrap) → DONE.
- DONE: exactly one cycle; HasDivE=1; DivLoE/DivHiE hold the result. → IDLE, or → SETUP if StartE=1 (back-to-back accept).
- Latency: start sampled at edge k → HasDivE high during cycle k+35 for WIDTH=32 (k+WIDTH+3 in general); divide-by-zero: cycle k+2.
- Divide by zero: DivLoE = all ones, DivHiE = raw SrcAE, DivByZeroE=1 for that DONE cycle. DivByZeroE=0 on every non-zero result.
- Overflow 0x80000000 / 0xFFFFFFFF signed: DivLoE=0x80000000, DivHiE=0, no flag.
- StallDiv combinational = (IDLE & StartE) | SETUP | ITER | FIXUP | (DONE & StartE). Low in the plain DONE cycle so the divide instruction advances with HasDivE.
- StartE is ignored in SETUP/ITER/FIXUP (already stalled; no re-latch).
- DivHiE/DivLoE retain the last result after DONE until the next DONE overwrites them. HasDivE is high only in DONE.
- reset during any state: next cycle IDLE, all outputs 0, StallDiv follows IDLE rule; no HasDivE is ever produced for the aborted divide.

Test Plan:
- DIVU 100/7, start at edge k → StallDiv high k..k+34, low k+35; HasDivE=1 only at k+35; DivLoE=14, DivHiE=2.
- DIV −7/2 (0xFFFFFFF9/0x00000002) → DivLoE=0xFFFFFFFD, DivHiE=0xFFFFFFFF. DIV 7/−2 → Lo=0xFFFFFFFD, Hi=1.
- DIVU 5/0 → HasDivE at k+2, DivLoE=0xFFFFFFFF, DivHiE=5, DivByZeroE=1. The following DIVU 9/3 gives Lo=3, Hi=0, DivByZeroE=0.
- DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0. DIVU 0xFFFFFFFF/1 → Lo=0xFFFFFFFF, Hi=0.
- reset asserted in 10th ITER cycle → next cycle IDLE, StallDiv=0 (StartE=0), outputs 0, HasDivE stays 0 for 40 cycles.
- StartE held high with new operands during ITER → ignored, first result correct. StartE=1 in DONE → HasDivE pulse, then immediate SETUP; second HasDivE 35 cycles later.
